// File: rtl/io_bus_bridge_pkg.sv
// Shared definitions for data-IO bus slaves: bus widths, mem_ctrl layout,
// peripheral map, and byte-lane / load-extension helpers.
package io_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int CTRL_W = 4;
  localparam int DATA_W = 32;

  localparam int CTRL_WE_BIT   = 0;
  localparam int CTRL_TYPE_LSB = 1;
  localparam int CTRL_UNS_BIT  = 3;

  typedef enum logic [1:0] {
    MT_WORD = 2'b00,
    MT_HALF = 2'b01,
    MT_BYTE = 2'b10,
    MT_RSVD = 2'b11
  } mem_type_e;

  localparam logic [11:0] OFF_SEG  = 12'h000;
  localparam logic [11:0] OFF_TCNT = 12'h020;
  localparam logic [11:0] OFF_TDIV = 12'h024;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_F000;

  function automatic mem_type_e ctrl_type(input logic [CTRL_W-1:0] ctrl);
    return mem_type_e'(ctrl[CTRL_TYPE_LSB +: 2]);
  endfunction

  // Reserved type falls through to word in every helper below.
  function automatic logic [3:0] lane_en(input mem_type_e t, input logic [1:0] a);
    logic [3:0] en;
    case (t)
      MT_BYTE: en = 4'b0001 << a;
      MT_HALF: en = a[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  function automatic logic [DATA_W-1:0] store_rep(input mem_type_e t, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] r;
    case (t)
      MT_BYTE: r = {4{wd[7:0]}};
      MT_HALF: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input mem_type_e t, input logic uns,
                                                 input logic [1:0] a, input logic [DATA_W-1:0] w);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      MT_BYTE: r = {{24{b[7] & ~uns}}, b};
      MT_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_bus_bridge_if.sv
// Core data-IO bus as driven by the MEM stage; the bridge attaches as slave.
interface io_bus_if;
  import io_bus_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport master (output mem_addr, mem_ctrl, mem_wd, mem_we, input mem_rd);
  modport slave  (input mem_addr, mem_ctrl, mem_wd, mem_we, output mem_rd);
endinterface

// File: rtl/io_bus_bridge_timer.sv
// Free-running timer: prescaler divides the clock by TIMER_DIV (0 acts as 1)
// and bumps TIMER_CNT on each prescaler wrap.
module io_timer
  import io_bus_pkg::*;
#(
  parameter logic [31:0] DIV_RESET = 32'd100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cnt_we,
  input  logic              i_div_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [31:0]       o_cnt,
  output logic [31:0]       o_div
);

  logic [31:0] r_presc;
  logic [31:0] r_cnt;
  logic [31:0] r_div;
  logic [31:0] w_last;
  logic        w_tick;

  always_comb begin
    w_last = (r_div == 32'd0) ? 32'd0 : (r_div - 32'd1);
    w_tick = (r_presc >= w_last);
  end

  // A DIV write restarts the prescale period; a CNT write overrides any tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 32'd0;
      r_cnt   <= 32'd0;
      r_div   <= DIV_RESET;
    end else begin
      if (i_div_we) begin
        r_div   <= i_wdata;
        r_presc <= 32'd0;
      end else if (w_tick) begin
        r_presc <= 32'd0;
      end else begin
        r_presc <= r_presc + 32'd1;
      end

      if (i_cnt_we) begin
        r_cnt <= i_wdata;
      end else if (w_tick) begin
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_div = r_div;

endmodule

// File: rtl/io_bus_bridge.sv
// Data-IO bus slave: routes MEM-stage accesses to a byte-writable data RAM or
// to the peripheral window (seven-seg, timer, LEDs, switches).
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int          DRAM_AW         = 14,
  parameter logic [31:0] PERIPH_BASE     = PERIPH_BASE_DEFAULT,
  parameter int          SW_W            = 24,
  parameter logic [31:0] TIMER_DIV_RESET = 32'd100
) (
  input  logic            clk,
  input  logic            rst,
  io_bus_if.slave         bus,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] led_o,
  output logic [31:0]     seg_o
);

  logic [DATA_W-1:0]  r_ram [0:(2**DRAM_AW)-1];
  logic [SW_W-1:0]    r_sw_meta;
  logic [SW_W-1:0]    r_sw_sync;
  logic [SW_W-1:0]    r_led;
  logic [31:0]        r_seg;

  logic               w_periph;
  logic               w_store;
  logic               w_ram_we;
  logic               w_cnt_we;
  logic               w_div_we;
  logic [DRAM_AW-1:0] w_widx;
  logic [11:0]        w_off;
  mem_type_e          w_type;
  logic [3:0]         w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_ram_word;
  logic [DATA_W-1:0]  w_periph_rd;
  logic [31:0]        w_sw_ext;
  logic [31:0]        w_led_ext;
  logic [31:0]        w_cnt;
  logic [31:0]        w_div;

  // A store needs both strobes to agree; stores under reset are dropped.
  always_comb begin
    w_periph = (bus.mem_addr[31:12] == PERIPH_BASE[31:12]);
    w_store  = bus.mem_we & bus.mem_ctrl[CTRL_WE_BIT] & ~rst;
    w_widx   = bus.mem_addr[DRAM_AW+1:2];
    w_off    = bus.mem_addr[11:0];
    w_type   = ctrl_type(bus.mem_ctrl);
    w_be     = lane_en(w_type, bus.mem_addr[1:0]);
    w_wdata  = store_rep(w_type, bus.mem_wd);
    w_ram_we = w_store & ~w_periph;
    w_cnt_we = w_store & w_periph & (w_off == OFF_TCNT);
    w_div_we = w_store & w_periph & (w_off == OFF_TDIV);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_ram_we && w_be[i]) begin
        r_ram[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Peripheral registers are always written as full words from unreplicated data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_led     <= '0;
      r_seg     <= 32'd0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
      if (w_store && w_periph && (w_off == OFF_SEG)) begin
        r_seg <= bus.mem_wd;
      end
      if (w_store && w_periph && (w_off == OFF_LED)) begin
        r_led <= bus.mem_wd[SW_W-1:0];
      end
    end
  end

  io_timer #(
    .DIV_RESET (TIMER_DIV_RESET)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_cnt_we (w_cnt_we),
    .i_div_we (w_div_we),
    .i_wdata  (bus.mem_wd),
    .o_cnt    (w_cnt),
    .o_div    (w_div)
  );

  always_comb begin
    w_sw_ext             = 32'd0;
    w_sw_ext[SW_W-1:0]   = r_sw_sync;
    w_led_ext            = 32'd0;
    w_led_ext[SW_W-1:0]  = r_led;
    case (w_off)
      OFF_SEG:  w_periph_rd = r_seg;
      OFF_TCNT: w_periph_rd = w_cnt;
      OFF_TDIV: w_periph_rd = w_div;
      OFF_LED:  w_periph_rd = w_led_ext;
      OFF_SW:   w_periph_rd = w_sw_ext;
      default:  w_periph_rd = 32'd0;
    endcase
  end

  // Zero-latency load path; the core registers mem_rd itself.
  always_comb begin
    w_ram_word = r_ram[w_widx];
    if (w_periph) begin
      bus.mem_rd = w_periph_rd;
    end else begin
      bus.mem_rd = load_ext(w_type, bus.mem_ctrl[CTRL_UNS_BIT], bus.mem_addr[1:0], w_ram_word);
    end
  end

  assign led_o = r_led;
  assign seg_o = r_seg;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: directed scenarios plus randomized
// RAM traffic checked against a byte-level memory model.
module tb_io_bus_bridge;
  import io_bus_pkg::*;

  localparam logic [31:0] PB = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw_i;
  logic [23:0] led_o;
  logic [31:0] seg_o;

  io_bus_if bus ();

  io_bus_bridge #(
    .DRAM_AW         (14),
    .PERIPH_BASE     (32'hFFFF_F000),
    .SW_W            (24),
    .TIMER_DIV_RESET (32'd100)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .sw_i  (sw_i),
    .led_o (led_o),
    .seg_o (seg_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl [int];

  function automatic void mdl_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    int b;
    b = int'(a[15:0]);
    if (t == 2'b10) begin
      mdl[b] = d[7:0];
    end else if (t == 2'b01) begin
      b = b & ~1;
      mdl[b]   = d[7:0];
      mdl[b+1] = d[15:8];
    end else begin
      b = b & ~3;
      for (int i = 0; i < 4; i++) mdl[b+i] = d[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] t, input logic u);
    int b;
    logic [31:0] v;
    b = int'(a[15:0]);
    if (t == 2'b10) begin
      v = {24'd0, mdl[b]};
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (t == 2'b01) begin
      b = b & ~1;
      v = {16'd0, mdl[b+1], mdl[b]};
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      b = b & ~3;
      v = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    end
    return v;
  endfunction

  task automatic bus_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    @(negedge clk);
    bus.mem_addr = a;
    bus.mem_ctrl = {1'b0, t, 1'b1};
    bus.mem_wd   = d;
    bus.mem_we   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_we   = 1'b0;
    bus.mem_ctrl = 4'b0000;
  endtask

  task automatic bus_load(input logic [31:0] a, input logic [1:0] t, input logic u, output logic [31:0] d);
    @(negedge clk);
    bus.mem_addr = a;
    bus.mem_ctrl = {u, t, 1'b0};
    bus.mem_we   = 1'b0;
    #1;
    d = bus.mem_rd;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    bus_store(PB | 32'h060, 2'b00, 32'h0012_3456);
    bus_store(PB | 32'h000, 2'b00, 32'hDEAD_BEEF);
    bus_store(PB | 32'h024, 2'b00, 32'd7);
    bus_store(PB | 32'h020, 2'b00, 32'h0000_0055);
    n_vec++;
    if (seg_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL reset_pre_seg got=%h exp=%h", seg_o, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (led_o !== 24'd0) begin
      n_err++; $display("FAIL reset_led got=%h exp=%h", led_o, 24'd0);
    end
    n_vec++;
    if (seg_o !== 32'd0) begin
      n_err++; $display("FAIL reset_seg got=%h exp=%h", seg_o, 32'd0);
    end
    bus.mem_addr = PB | 32'h024;
    bus.mem_ctrl = 4'b0000;
    bus.mem_we   = 1'b0;
    #1;
    got = bus.mem_rd;
    n_vec++;
    if (got !== 32'd100) begin
      n_err++; $display("FAIL reset_div got=%h exp=%h", got, 32'd100);
    end
    bus.mem_addr = PB | 32'h020;
    #1;
    got = bus.mem_rd;
    n_vec++;
    if (got !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt got=%h exp=%h", got, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] got;
    logic [31:0] exp [4];
    exp[0] = 32'hFFFF_FF83; exp[1] = 32'hFFFF_FF82;
    exp[2] = 32'hFFFF_FF81; exp[3] = 32'hFFFF_FF80;
    bus_store(32'h10, 2'b00, 32'h8081_8283);
    mdl_store(32'h10, 2'b00, 32'h8081_8283);
    for (int i = 0; i < 4; i++) begin
      bus_load(32'h10 + i, 2'b10, 1'b0, got);
      n_vec++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL byte_signed[%0d] got=%h exp=%h", i, got, exp[i]);
      end
    end
    bus_load(32'h13, 2'b10, 1'b1, got);
    n_vec++;
    if (got !== 32'h0000_0080) begin
      n_err++; $display("FAIL byte_unsigned got=%h exp=%h", got, 32'h0000_0080);
    end
  endtask

  task automatic test_half();
    logic [31:0] got;
    bus_store(32'h20, 2'b00, 32'd0);
    bus_store(32'h22, 2'b01, 32'h1234_BEEF);
    mdl_store(32'h20, 2'b00, 32'd0);
    mdl_store(32'h22, 2'b01, 32'h1234_BEEF);
    bus_load(32'h20, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== 32'hBEEF_0000) begin
      n_err++; $display("FAIL half_store_word got=%h exp=%h", got, 32'hBEEF_0000);
    end
    bus_load(32'h23, 2'b01, 1'b0, got);
    n_vec++;
    if (got !== 32'hFFFF_BEEF) begin
      n_err++; $display("FAIL half_load_signed got=%h exp=%h", got, 32'hFFFF_BEEF);
    end
  endtask

  task automatic test_strobe_mismatch();
    logic [31:0] got;
    bus_store(32'h30, 2'b00, 32'h1122_3344);
    mdl_store(32'h30, 2'b00, 32'h1122_3344);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.mem_addr = 32'h31;
      bus.mem_ctrl = {1'b0, 2'b10, (i == 1) ? 1'b1 : 1'b0};
      bus.mem_wd   = 32'h0000_00AA;
      bus.mem_we   = (i == 1) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      bus.mem_we   = 1'b0;
      bus.mem_ctrl = 4'b0000;
      bus_load(32'h30, 2'b00, 1'b0, got);
      n_vec++;
      if (got !== 32'h1122_3344) begin
        n_err++; $display("FAIL strobe_mismatch[%0d] got=%h exp=%h", i, got, 32'h1122_3344);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] got;
    bus_load(PB | 32'h100, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== 32'd0) begin
      n_err++; $display("FAIL unmapped_read got=%h exp=%h", got, 32'd0);
    end
    bus_store(PB | 32'h004, 2'b00, $urandom);
    bus_load(PB | 32'h004, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== 32'd0) begin
      n_err++; $display("FAIL unmapped_write got=%h exp=%h", got, 32'd0);
    end
  endtask

  task automatic timer_run(input logic [31:0] div, input logic [31:0] w);
    logic [31:0] got, exp;
    int d_eff, p1;
    bus_store(PB | 32'h024, 2'b00, div);
    bus_store(PB | 32'h020, 2'b00, w);
    d_eff = (div == 32'd0) ? 1 : int'(div);
    p1 = 1 % d_eff;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.mem_addr = PB | 32'h020;
      bus.mem_ctrl = 4'b0000;
      bus.mem_we   = 1'b0;
      #1;
      got = bus.mem_rd;
      exp = w + 32'((p1 + k) / d_eff);
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL timer_cnt div=%0d k=%0d got=%h exp=%h", div, k, got, exp);
      end
    end
    bus_load(PB | 32'h024, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== div) begin
      n_err++; $display("FAIL timer_div got=%h exp=%h", got, div);
    end
  endtask

  task automatic test_timer();
    timer_run(32'd3, 32'hFFFF_FFFF);
    timer_run(32'd0, 32'd5);
    timer_run(32'd1, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) timer_run(32'($urandom_range(2, 6)), $urandom);
  endtask

  task automatic test_switch_led();
    logic [31:0] got;
    logic [23:0] old_v, new_v;
    logic [31:0] seg_v;
    old_v = 24'd0;
    for (int r = 0; r < 3; r++) begin
      new_v = (r == 0) ? 24'h00A5A5 : 24'($urandom);
      @(posedge clk);
      #1;
      sw_i = new_v;
      bus.mem_addr = PB | 32'h070;
      bus.mem_ctrl = 4'b0000;
      bus.mem_we   = 1'b0;
      for (int e = 0; e < 3; e++) begin
        #1;
        got = bus.mem_rd;
        n_vec++;
        if (got !== {8'd0, (e == 2) ? new_v : old_v}) begin
          n_err++; $display("FAIL sw_sync r=%0d edge=%0d got=%h exp=%h", r, e, got, {8'd0, (e == 2) ? new_v : old_v});
        end
        if (e < 2) begin
          @(posedge clk);
        end
      end
      old_v = new_v;
    end
    bus_store(PB | 32'h060, 2'b00, 32'hFFFF_FFFF);
    n_vec++;
    if (led_o !== 24'hFF_FFFF) begin
      n_err++; $display("FAIL led_out got=%h exp=%h", led_o, 24'hFF_FFFF);
    end
    bus_load(PB | 32'h060, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== 32'h00FF_FFFF) begin
      n_err++; $display("FAIL led_read got=%h exp=%h", got, 32'h00FF_FFFF);
    end
    seg_v = $urandom;
    bus_store(PB | 32'h000, 2'b10, seg_v);
    n_vec++;
    if (seg_o !== seg_v) begin
      n_err++; $display("FAIL seg_out got=%h exp=%h", seg_o, seg_v);
    end
    bus_store(PB | 32'h070, 2'b00, 32'h0000_1234);
    bus_load(PB | 32'h070, 2'b00, 1'b0, got);
    n_vec++;
    if (got !== {8'd0, old_v}) begin
      n_err++; $display("FAIL sw_readonly got=%h exp=%h", got, {8'd0, old_v});
    end
  endtask

  task automatic test_random_ram();
    logic [31:0] a, d, got, exp;
    logic [1:0]  t;
    logic        u;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      bus_store(32'h400 + 32'(4 * i), 2'b00, d);
      mdl_store(32'h400 + 32'(4 * i), 2'b00, d);
    end
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 32767)) << 16) | (32'h400 + 32'($urandom_range(0, 127)));
      t = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        bus_store(a, t, d);
        mdl_store(a, t, d);
      end
      bus_load(a ^ (32'($urandom_range(0, 3)) << 20), t, u, got);
      exp = mdl_load(a, t, u);
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL rand_ram n=%0d addr=%h type=%0d uns=%0d got=%h exp=%h", n, a, t, u, got, exp);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    sw_i         = 24'd0;
    bus.mem_addr = 32'd0;
    bus.mem_ctrl = 4'b0000;
    bus.mem_wd   = 32'd0;
    bus.mem_we   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_byte_lanes();
    test_half();
    test_strobe_mismatch();
    test_unmapped();
    test_timer();
    test_switch_led();
    test_random_ram();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
